// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD up/down counter slice: digit width, digit
// bounds, the digit type and a helper that maps invalid BCD codes to zero.
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [3:0]  BCD_MIN = 4'd0;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Codes 10..15 are not BCD; they collapse to zero on load.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MIN : d;
  endfunction

  function automatic logic bcd_invalid(input bcd_digit_t d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// -----------------------------------------------------------------------------
// bcd_updown_digit
// One BCD digit with up/down step, synchronous clear and parallel load.
// Priority: clear > load > step > hold.
//
// Ports
//   i_Clk       rising-edge clock
//   i_nRst      asynchronous active-low reset (digit -> 0)
//   i_En        step this digit on the next edge (carry/borrow already folded in)
//   i_Dir       1 = up, 0 = down
//   i_Clr       synchronous clear
//   i_Load      synchronous load of i_LoadDigit
//   i_LoadDigit value to load (already sanitized to 0..9)
//   o_Digit     registered digit value
//   o_At9       digit equals 9 (decoded from the register)
//   o_At0       digit equals 0 (decoded from the register)
// -----------------------------------------------------------------------------
module bcd_updown_digit
  import bcd_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_nRst,
  input  logic       i_En,
  input  logic       i_Dir,
  input  logic       i_Clr,
  input  logic       i_Load,
  input  bcd_digit_t i_LoadDigit,
  output bcd_digit_t o_Digit,
  output logic       o_At9,
  output logic       o_At0
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    // NOTE: default first so every path assigns digit_d and no latch is inferred.
    digit_d = digit_q;
    if (i_Clr) begin
      digit_d = BCD_MIN;
    end else if (i_Load) begin
      digit_d = i_LoadDigit;
    end else if (i_En) begin
      if (i_Dir) digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      else       digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    // NOTE: non-blocking assignment for registered state avoids simulation races.
    if (!i_nRst) digit_q <= BCD_MIN;
    else         digit_q <= digit_d;
  end

  assign o_Digit = digit_q;
  assign o_At9   = (digit_q == BCD_MAX);
  assign o_At0   = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
// Cascadable P_DIGITS-digit BCD up/down counter with wrap or saturate at the
// terminal count (all 9 going up, all 0 going down).
// Priority per cycle: clear > load > count enable > hold.
//
// Optional feature: define BCD_CNT_LOAD_EN to add a parallel load
// (i_Load, i_LoadVal, o_LoadErr). Invalid digits (>9) load as 0 and pulse
// o_LoadErr for one cycle.
//
// Parameters
//   P_DIGITS  number of BCD digits (1..8)
//   P_WRAP    1 = wrap at terminal count, 0 = saturate
// Ports
//   i_Clk     rising-edge clock
//   i_nRst    asynchronous active-low reset
//   i_CntEn   one step per enabled cycle
//   i_Dir     1 = up, 0 = down
//   i_Clr     synchronous clear
//   o_Cout    packed BCD value, digit 0 in [3:0] (registered)
//   o_NextEn  combinational cascade enable for a following counter
//   o_Zero    all digits zero (decoded from registers)
//   o_Sat     registered saturation flag (P_WRAP = 0 only)
// -----------------------------------------------------------------------------
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int P_DIGITS = 4,
  parameter int P_WRAP   = 1
) (
  input  logic                      i_Clk,
  input  logic                      i_nRst,
  input  logic                      i_CntEn,
  input  logic                      i_Dir,
  input  logic                      i_Clr,
  output logic [BCD_W*P_DIGITS-1:0] o_Cout,
  output logic                      o_NextEn,
  output logic                      o_Zero,
  output logic                      o_Sat
`ifdef BCD_CNT_LOAD_EN
  ,
  input  logic                      i_Load,
  input  logic [BCD_W*P_DIGITS-1:0] i_LoadVal,
  output logic                      o_LoadErr
`endif
);

  localparam bit WRAP = (P_WRAP != 0);

  logic [P_DIGITS-1:0] at9;
  logic [P_DIGITS-1:0] at0;
  // term_chain[k]: digits 0..k-1 are all at the terminal digit for i_Dir.
  logic [P_DIGITS:0]   term_chain;
  logic                terminal;
  logic                load;
  logic                step_en;
  logic                sat_q;
  bcd_digit_t          load_digit [P_DIGITS];

`ifdef BCD_CNT_LOAD_EN
  logic load_bad;
  logic load_err_q;

  assign load = i_Load & ~i_Clr;

  always_comb begin
    load_bad = 1'b0;
    for (int k = 0; k < P_DIGITS; k++) begin
      load_bad      = load_bad | bcd_invalid(i_LoadVal[k*BCD_W +: BCD_W]);
      load_digit[k] = bcd_sanitize(i_LoadVal[k*BCD_W +: BCD_W]);
    end
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) load_err_q <= 1'b0;
    else         load_err_q <= load & load_bad;
  end

  assign o_LoadErr = load_err_q;
`else
  assign load = 1'b0;

  always_comb begin
    for (int k = 0; k < P_DIGITS; k++) load_digit[k] = BCD_MIN;
  end
`endif

  assign term_chain[0] = 1'b1;
  assign terminal      = term_chain[P_DIGITS];

  // In saturate mode a step at the terminal count is simply suppressed.
  assign step_en = i_CntEn & ~i_Clr & ~load & ~(~WRAP & terminal);

  for (genvar k = 0; k < P_DIGITS; k++) begin : g_digit
    bcd_digit_t digit;

    assign term_chain[k+1] = term_chain[k] & (i_Dir ? at9[k] : at0[k]);

    bcd_updown_digit u_digit (
      .i_Clk       (i_Clk),
      .i_nRst      (i_nRst),
      .i_En        (step_en & term_chain[k]),
      .i_Dir       (i_Dir),
      .i_Clr       (i_Clr),
      .i_Load      (load),
      .i_LoadDigit (load_digit[k]),
      .o_Digit     (digit),
      .o_At9       (at9[k]),
      .o_At0       (at0[k])
    );

    assign o_Cout[k*BCD_W +: BCD_W] = digit;
  end

  // Saturation: set after a blocked step, cleared by any real step (which can
  // only be in the opposite direction), clear or load.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst)               sat_q <= 1'b0;
    else if (i_Clr || load)    sat_q <= 1'b0;
    else if (i_CntEn && !WRAP) sat_q <= terminal;
  end

  assign o_Sat    = sat_q;
  assign o_Zero   = &at0;
  // Gated by i_nRst so the cascade stays quiet while the counter is in reset.
  assign o_NextEn = i_nRst & i_CntEn & terminal & ~i_Clr & ~load & (WRAP | ~sat_q);

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter P_DIGITS, default 4, number of cascaded BCD digits (1..8).
REQ-002 SHALL have parameter P_WRAP, default 1; 1 = wrap at terminal count, 0 = saturate at terminal count.
REQ-003 SHALL have port i_Clk, input, 1 bit; the single clock, rising-edge active.
REQ-004 SHALL have port i_nRst, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port i_CntEn, input, 1 bit; count enable for one step per cycle.
REQ-006 SHALL have port i_Dir, input, 1 bit; 1 = count up, 0 = count down.
REQ-007 SHALL have port i_Clr, input, 1 bit; synchronous clear to zero.
REQ-008 SHALL have port o_Cout, output, 4*P_DIGITS bits; packed BCD value, digit 0 in bits [3:0].
REQ-009 SHALL have port o_NextEn, output, 1 bit; cascade enable for a following counter.
REQ-010 SHALL have port o_Zero, output, 1 bit; high when all digits are 0.
REQ-011 SHALL have port o_Sat, output, 1 bit; registered flag, high while saturated (P_WRAP=0 only).

Function
REQ-012 SHALL apply per-cycle priority i_Clr > load (see Configuration) > i_CntEn > hold.
REQ-013 SHALL, on a count-up step, increment digit 0 and ripple the carry to digit k+1 only when digits 0..k all equal 9; a digit at 9 that receives a carry goes to 0.
REQ-014 SHALL, on a count-down step, decrement digit 0 and ripple the borrow to digit k+1 only when digits 0..k all equal 0; a digit at 0 that receives a borrow goes to 9.
REQ-015 SHALL define the terminal count as all digits 9 when i_Dir=1, and all digits 0 when i_Dir=0.
REQ-016 SHALL, with P_WRAP=1, wrap from all-9 to all-0 going up and from all-0 to all-9 going down, in one cycle.
REQ-017 SHALL, with P_WRAP=0, hold the value at terminal count while counting further in the same direction, and set o_Sat on the cycle after the blocked step.
REQ-018 SHALL clear o_Sat on any clear, load, or step in the opposite direction.
REQ-019 SHALL drive o_NextEn combinationally: i_CntEn & terminal count & !i_Clr & !load & (P_WRAP | !o_Sat).
REQ-020 SHALL take effect on an i_Dir change at the next enabled edge, with no dead cycle.
REQ-021 SHALL never produce a digit value above 9 on o_Cout.
REQ-022 SHALL drive o_Cout and o_Zero directly from registers, or decode them from registers only, with no input-to-output path.

Reset
REQ-023 SHALL, while i_nRst=0, drive o_Cout=0, o_Zero=1, o_Sat=0, o_NextEn=0, and any load-error flag to 0, independent of i_Clk.
REQ-024 SHALL, on a reset asserted mid-count, abort the count immediately and resume from 0 at the first enabled edge after release.

Configuration
REQ-025 SHALL compile in a parallel-load feature when macro BCD_CNT_LOAD_EN is defined.
REQ-026 SHALL, with BCD_CNT_LOAD_EN defined, add the following ports:
- i_Load: input, 1 bit.
- i_LoadVal: input, 4*P_DIGITS bits.
- o_LoadErr: output, 1 bit, registered.
REQ-027 SHALL, when i_Load=1, load i_LoadVal, replacing any digit greater than 9 with 0, and pulse o_LoadErr for exactly one cycle if any digit was replaced.
REQ-028 SHALL, without BCD_CNT_LOAD_EN, have no load ports, and the load term in REQ-012/REQ-019 SHALL be constant 0.

Structure
REQ-029 SHALL place the following in shared package bcd_pkg:
- BCD_W = 4.
- BCD_MAX = 4'd9.
- BCD_MIN = 4'd0.
- typedef bcd_digit_t.
REQ-030 SHALL instantiate P_DIGITS copies of a single sub-module, bcd_updown_digit (inputs: enable, direction, clear, load, load digit; outputs: digit, digit-at-9, digit-at-0), chained by generate.

Verification
REQ-031 SHALL cover wrap up: P_DIGITS=2, P_WRAP=1, value 98, i_Dir=1, i_CntEn=1 for 2 cycles -> values 99 then 00; o_NextEn=1 only during the 99 cycle.
REQ-032 SHALL cover wrap down: value 00, i_Dir=0, one step -> value 99; o_Zero=1 before the step, 0 after.
REQ-033 SHALL cover saturation: P_WRAP=0, value 9999, up for 3 cycles -> value holds 9999, o_Sat=1 from the 2nd cycle, o_NextEn=0 once saturated; one down step -> 9998, o_Sat=0.
REQ-034 SHALL cover priority: i_Clr=1, i_Load=1, i_CntEn=1 at value 0457 -> 0000, o_LoadErr=0.
REQ-035 SHALL cover load with invalid digits: i_LoadVal=0x3A7F -> value 3070 next cycle, o_LoadErr high for exactly one cycle.
REQ-036 SHALL cover async reset: drop i_nRst mid-count at value 1234 between clock edges -> outputs 0000/o_Zero=1 immediately; after release, count resumes at 0001 on the first enabled edge.
